// File: rtl/vdp_bitmap.sv
// Bitmap VDP: 640x480@60 VGA timing and a 256x192 1-bpp framebuffer shown pixel-doubled in a border.
// One 32-byte line buffer is refilled from shared SRAM during horizontal blanking, every second line.
module vdp_bitmap #(
  parameter logic [15:0] BASE_ADDR  = 16'h6000,
  parameter logic [11:0] FG_RGB     = 12'hFFF,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter logic [11:0] BORDER_RGB = 12'h008
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ram_grant,
  input  logic [7:0]  ram_data,
  output logic [15:0] vdp_addr,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank,
  output logic        underrun
);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e      state_q;
  logic [9:0]  hcount_q, vcount_q;
  logic [5:0]  issue_idx_q;
  logic [7:0]  sy_q;
  logic        cap_vld_q;
  logic [4:0]  cap_idx_q;
  logic [15:0] addr_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, vblank_q, underrun_q;
  logic [7:0]  line_buf_q [32];

  logic        h_wrap, v_wrap, fetch_start, issue, cap_last;
  logic [7:0]  sy_start, hpix, rd_byte;
  logic        in_win, visible;

  function automatic logic [15:0] line_addr(input logic [7:0] sy, input logic [5:0] idx);
    return BASE_ADDR + {3'b000, sy, 5'b00000} + {10'd0, idx};
  endfunction

  assign h_wrap   = (hcount_q == 10'd799);
  assign v_wrap   = (vcount_q == 10'd524);
  // Fetch during line n-1 for even-offset display lines n, so both doubled lines share it.
  assign fetch_start = (state_q == IDLE) && (hcount_q == 10'd576) &&
                       (vcount_q >= 10'd47) && (vcount_q <= 10'd429) && vcount_q[0];
  assign sy_start = 8'((vcount_q - 10'd47) >> 1);
  assign issue    = (state_q == FETCH) && ram_grant && !issue_idx_q[5];
  assign cap_last = (state_q == FETCH) && cap_vld_q && (cap_idx_q == 5'd31);

  assign hpix    = 8'((hcount_q - 10'd64) >> 1);
  assign rd_byte = line_buf_q[hpix[7:3]];
  assign in_win  = (hcount_q >= 10'd64) && (hcount_q <= 10'd575) &&
                   (vcount_q >= 10'd48) && (vcount_q <= 10'd431);
  assign visible = (hcount_q < 10'd640) && (vcount_q < 10'd480);

  always_comb begin
    rgb_d = 12'h000;
    if (visible) begin
      if (in_win) rgb_d = rd_byte[~hpix[2:0]] ? FG_RGB : BG_RGB;
      else        rgb_d = BORDER_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      state_q     <= IDLE;
      issue_idx_q <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      addr_q      <= BASE_ADDR;
      rgb_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      vblank_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hcount_q <= h_wrap ? 10'd0 : hcount_q + 10'd1;
      if (h_wrap) vcount_q <= v_wrap ? 10'd0 : vcount_q + 10'd1;

      cap_vld_q <= issue;
      cap_idx_q <= issue_idx_q[4:0];

      case (state_q)
        IDLE: begin
          if (fetch_start) begin
            state_q     <= FETCH;
            sy_q        <= sy_start;
            issue_idx_q <= '0;
            addr_q      <= line_addr(sy_start, 6'd0);
          end
        end
        FETCH: begin
          if (issue) begin
            issue_idx_q <= issue_idx_q + 6'd1;
            addr_q      <= line_addr(sy_q, 6'(issue_idx_q + 6'd1));
          end
          if (cap_last || h_wrap) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      rgb_q      <= rgb_d;
      hsync_q    <= !((hcount_q >= 10'd656) && (hcount_q <= 10'd751));
      vsync_q    <= !((vcount_q >= 10'd490) && (vcount_q <= 10'd491));
      vblank_q   <= (vcount_q >= 10'd480);
      underrun_q <= (state_q == FETCH) && h_wrap && !cap_last;
    end
  end

  // Captures are dropped once the FSM has left FETCH, so an abandoned fetch leaves stale data.
  always_ff @(posedge clk) begin
    if (reset_n && cap_vld_q && (state_q == FETCH))
      line_buf_q[cap_idx_q] <= ram_data;
  end

  assign vdp_addr = addr_q;
  assign r        = rgb_q[11:8];
  assign g        = rgb_q[7:4];
  assign b        = rgb_q[3:0];
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign vblank   = vblank_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vdp_bitmap.sv
// Bench for vdp_bitmap: SRAM model with random framebuffer, frame-position arithmetic as the reference.
module tb_vdp_bitmap;
  localparam logic [15:0] BASE   = 16'h6000;
  localparam logic [11:0] FG     = 12'hFFF;
  localparam logic [11:0] BG     = 12'h000;
  localparam logic [11:0] BORDER = 12'h008;

  logic        clk = 1'b0;
  logic        reset_n, ram_grant;
  logic [7:0]  ram_data;
  logic [15:0] vdp_addr;
  logic [3:0]  r, g, b;
  logic        hsync, vsync, vblank, underrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem  [0:65535];
  logic [7:0] mbuf [0:31];
  int         acnt [0:31];

  always #5 clk = ~clk;

  vdp_bitmap dut (
    .clk(clk), .reset_n(reset_n), .ram_grant(ram_grant), .ram_data(ram_data),
    .vdp_addr(vdp_addr), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .vblank(vblank), .underrun(underrun)
  );

  // Colour expected for a dot at (h, v) given the line content the bench believes is buffered.
  function automatic logic [11:0] exp_rgb(int h, int v);
    int bi, ki;
    logic [7:0] bv;
    if (v < 480 && h < 640) begin
      if (h >= 64 && h <= 575 && v >= 48 && v <= 431) begin
        bi = (h - 64) / 16;
        ki = 7 - (((h - 64) / 2) % 8);
        bv = mbuf[bi];
        return bv[ki] ? FG : BG;
      end
      return BORDER;
    end
    return 12'h000;
  endfunction

  initial begin
    int mh, mv, ph, pv, gph, post, bad48, sy;
    bit have_prev;
    logic [15:0] prev_addr;
    logic [3:0]  exp_ctl;

    reset_n = 1'b0; ram_grant = 1'b0; ram_data = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 6144; i++) mem[BASE + 16'(i)] = 8'($urandom);
    mem[BASE] = 8'h80;
    for (int i = 1; i < 32; i++) mem[BASE + 16'(i)] = 8'h00;
    for (int i = 0; i < 32; i++) begin mbuf[i] = 8'h00; acnt[i] = 0; end

    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      assert ({r, g, b} === 12'h000) else begin
        errors++; $error("FAIL reset_rgb got %h exp %h", {r, g, b}, 12'h000);
      end
      checks++;
      assert ({hsync, vsync, vblank, underrun} === 4'b1100) else begin
        errors++; $error("FAIL reset_ctl got %b exp %b", {hsync, vsync, vblank, underrun}, 4'b1100);
      end
      checks++;
      assert (vdp_addr === BASE) else begin
        errors++; $error("FAIL reset_addr got %h exp %h", vdp_addr, BASE);
      end
    end

    reset_n = 1'b1;
    mh = 0; mv = 0; ph = 0; pv = 0; gph = 0; post = -1; bad48 = 0;
    have_prev = 1'b0;
    prev_addr = vdp_addr;

    while (post != 0) begin
      if (have_prev) begin
        checks++;
        assert ({r, g, b} === exp_rgb(ph, pv)) else begin
          errors++; $error("FAIL rgb h=%0d v=%0d got %h exp %h", ph, pv, {r, g, b}, exp_rgb(ph, pv));
        end
        exp_ctl = {!(ph >= 656 && ph <= 751), !(pv >= 490 && pv <= 491), (pv >= 480),
                   (ph == 799 && pv == 51)};
        checks++;
        assert ({hsync, vsync, vblank, underrun} === exp_ctl) else begin
          errors++; $error("FAIL ctl h=%0d v=%0d got %b exp %b", ph, pv,
                           {hsync, vsync, vblank, underrun}, exp_ctl);
        end
      end
      if (post > 0) begin
        checks++;
        assert (vdp_addr === BASE) else begin
          errors++; $error("FAIL idle_addr_after_reset h=%0d got %h exp %h", mh, vdp_addr, BASE);
        end
        post--;
      end

      // Registered SRAM: data for the address of the previous cycle.
      ram_data  = mem[prev_addr];
      ram_grant = ((gph % 16) < 8) && !(mv == 51 && mh >= 576);
      if (mv == 49 && mh >= 577 && ram_grant &&
          vdp_addr >= BASE + 16'd32 && vdp_addr <= BASE + 16'd63)
        acnt[vdp_addr - BASE - 16'd32]++;
      if (mv == 48 && vdp_addr !== BASE + 16'd32) bad48++;
      prev_addr = vdp_addr;
      if (mv == 53 && mh == 600 && post < 0) reset_n = 1'b0;

      @(posedge clk); #1;
      gph++;

      if (!reset_n) begin
        checks++;
        assert (vdp_addr === BASE) else begin
          errors++; $error("FAIL midfetch_reset_addr got %h exp %h", vdp_addr, BASE);
        end
        checks++;
        assert ({r, g, b, hsync, vsync, vblank, underrun} === {12'h000, 4'b1100}) else begin
          errors++; $error("FAIL midfetch_reset_out got %h exp %h",
                           {r, g, b, hsync, vsync, vblank, underrun}, {12'h000, 4'b1100});
        end
        reset_n = 1'b1;
        mh = 0; mv = 0; have_prev = 1'b0; post = 1000;
      end else begin
        ph = mh; pv = mv; have_prev = 1'b1;
        mh++;
        if (mh == 800) begin mh = 0; mv = (mv + 1) % 525; end
        if (mh == 0 && mv == 49) begin
          checks++;
          assert (bad48 === 0) else begin
            errors++; $error("FAIL no_fetch_line48 got %0d exp %0d", bad48, 0);
          end
        end
        if (mh == 0 && mv == 50) begin
          for (int i = 0; i < 32; i++) begin
            checks++;
            assert (acnt[i] === 1) else begin
              errors++; $error("FAIL issue_count idx=%0d got %0d exp %0d", i, acnt[i], 1);
            end
          end
        end
        // Completed fetch: buffer now holds source line (n-48)/2 for n = v+1.
        if (mh == 700 && (mv % 2) == 1 && mv >= 47 && mv <= 429 && mv != 51) begin
          sy = (mv + 1 - 48) / 2;
          for (int i = 0; i < 32; i++) mbuf[i] = mem[BASE + 16'(sy * 32 + i)];
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
